// File: rtl/weight_tile_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : weight_tile_loader_if
// Description : Command, byte-stream and weight-FIFO signals of the weight
//               tile loader, bundled with master (host) and slave (loader)
//               views.
// Revision    : 1.0 - initial release
// ============================================================================
interface weight_tile_loader_if;
    logic        start;
    logic [7:0]  num_tiles;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [63:0] wt_fifo_data;
    logic        wt_fifo_wr;
    logic        busy;
    logic        done;
    logic [7:0]  tile_count;
    logic        chk_err;

    modport master (
        output start, num_tiles, in_valid, in_data,
        input  in_ready, wt_fifo_data, wt_fifo_wr, busy, done, tile_count, chk_err
    );

    modport slave (
        input  start, num_tiles, in_valid, in_data,
        output in_ready, wt_fifo_data, wt_fifo_wr, busy, done, tile_count, chk_err
    );
endinterface
`default_nettype wire

// File: rtl/weight_tile_loader.sv
`default_nettype none
// ============================================================================
// Module      : weight_tile_loader
// Description : Packs a byte stream into weight rows (byte k in bits
//               [8k+7:8k]), pushes one row per FIFO strobe and counts rows
//               into tiles until the commanded tile count is reached.
//               Optional feature macro: WEIGHT_LOADER_CHECKSUM_EN adds a
//               per-tile XOR trailer byte and a sticky chk_err flag.
// Revision    : 1.0 - initial release
// ============================================================================
module weight_tile_loader #(
    parameter int ROWS_PER_TILE = 3,
    parameter int BYTES_PER_ROW = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    weight_tile_loader_if.slave  ldr
);

    localparam int                 c_ROW_W     = (ROWS_PER_TILE > 1) ? $clog2(ROWS_PER_TILE) : 1;
    localparam logic [c_ROW_W-1:0] c_LAST_ROW  = c_ROW_W'(ROWS_PER_TILE - 1);
    localparam logic [2:0]         c_LAST_BYTE = 3'(BYTES_PER_ROW - 1);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_COLLECT = 3'd1;
    localparam logic [2:0] c_ST_PUSH    = 3'd2;
    localparam logic [2:0] c_ST_DONE    = 3'd3;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    localparam logic [2:0] c_ST_CHECK   = 3'd4;
`endif

    typedef enum logic [2:0] {
        ST_IDLE    = c_ST_IDLE,
        ST_COLLECT = c_ST_COLLECT,
        ST_PUSH    = c_ST_PUSH,
        ST_DONE    = c_ST_DONE
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        , ST_CHECK = c_ST_CHECK
`endif
    } state_t;

    state_t             r_state,      w_state_next;
    logic [2:0]         r_byte_idx,   w_byte_idx_next;
    logic [c_ROW_W-1:0] r_row_idx,    w_row_idx_next;
    logic [7:0]         r_target,     w_target_next;
    logic [7:0]         r_tile_count, w_tile_count_next;
    logic [63:0]        r_row,        w_row_next;
    logic               r_wr,         w_wr_next;
    logic               r_busy,       w_busy_next;
    logic               r_done,       w_done_next;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [7:0]         r_xor,        w_xor_next;
    logic               r_chk_err,    w_chk_err_next;
`endif

    logic w_in_ready;
    logic w_xfer;
    logic w_start_ok;
    logic w_last_tile;

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    assign w_in_ready = (r_state == ST_COLLECT) || (r_state == ST_CHECK);
`else
    assign w_in_ready = (r_state == ST_COLLECT);
`endif
    assign w_xfer      = ldr.in_valid && w_in_ready;
    // busy also blocks the IDLE cycle that follows a zero-tile done pulse
    assign w_start_ok  = ldr.start && (r_state == ST_IDLE) && !r_busy;
    assign w_last_tile = ((r_tile_count + 8'd1) == r_target);

    // Next-state and next-output decode; every register holds unless changed
    always_comb begin
        w_state_next      = r_state;
        w_byte_idx_next   = r_byte_idx;
        w_row_idx_next    = r_row_idx;
        w_target_next     = r_target;
        w_tile_count_next = r_tile_count;
        w_row_next        = r_row;
        w_wr_next         = 1'b0;
        w_done_next       = 1'b0;
        w_busy_next       = r_busy && !r_done;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        w_xor_next        = r_xor;
        w_chk_err_next    = r_chk_err;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_busy_next       = 1'b1;
                    w_tile_count_next = 8'd0;
                    w_byte_idx_next   = 3'd0;
                    w_row_idx_next    = '0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                    w_xor_next        = 8'd0;
                    w_chk_err_next    = 1'b0;
`endif
                    if (ldr.num_tiles == 8'd0) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_target_next = ldr.num_tiles;
                        w_state_next  = ST_COLLECT;
                    end
                end
            end
            ST_COLLECT: begin
                if (w_xfer) begin
                    // first byte of a row wipes the previous row so stale lanes never leak
                    if (r_byte_idx == 3'd0) begin
                        w_row_next = 64'd0;
                    end
                    w_row_next[{r_byte_idx, 3'b000} +: 8] = ldr.in_data;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                    w_xor_next = r_xor ^ ldr.in_data;
`endif
                    w_byte_idx_next = r_byte_idx + 3'd1;
                    if (r_byte_idx == c_LAST_BYTE) begin
                        w_wr_next    = 1'b1;
                        w_state_next = ST_PUSH;
                    end
                end
            end
            ST_PUSH: begin
                w_byte_idx_next = 3'd0;
                if (r_row_idx == c_LAST_ROW) begin
                    w_row_idx_next    = '0;
                    w_tile_count_next = r_tile_count + 8'd1;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                    w_state_next = ST_CHECK;
`else
                    w_done_next  = w_last_tile;
                    w_state_next = w_last_tile ? ST_DONE : ST_COLLECT;
`endif
                end else begin
                    w_row_idx_next = r_row_idx + c_ROW_W'(1);
                    w_state_next   = ST_COLLECT;
                end
            end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (w_xfer) begin
                    if (ldr.in_data != r_xor) begin
                        w_chk_err_next = 1'b1;
                    end
                    w_xor_next = 8'd0;
                    // tile_count was already bumped in PUSH
                    if (r_tile_count == r_target) begin
                        w_done_next  = 1'b1;
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_COLLECT;
                    end
                end
            end
`endif
            ST_DONE: begin
                // a data-carrying command raised done on entry; the zero-tile path raises it here
                w_done_next  = !r_done;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_byte_idx   <= 3'd0;
            r_row_idx    <= '0;
            r_target     <= 8'd0;
            r_tile_count <= 8'd0;
            r_row        <= 64'd0;
            r_wr         <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            r_xor        <= 8'd0;
            r_chk_err    <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_next;
            r_byte_idx   <= w_byte_idx_next;
            r_row_idx    <= w_row_idx_next;
            r_target     <= w_target_next;
            r_tile_count <= w_tile_count_next;
            r_row        <= w_row_next;
            r_wr         <= w_wr_next;
            r_busy       <= w_busy_next;
            r_done       <= w_done_next;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            r_xor        <= w_xor_next;
            r_chk_err    <= w_chk_err_next;
`endif
        end
    end

    assign ldr.in_ready     = w_in_ready;
    assign ldr.wt_fifo_data = r_row;
    assign ldr.wt_fifo_wr   = r_wr;
    assign ldr.busy         = r_busy;
    assign ldr.done         = r_done;
    assign ldr.tile_count   = r_tile_count;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    assign ldr.chk_err      = r_chk_err;
`else
    assign ldr.chk_err      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_weight_tile_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_weight_tile_loader
// Description : Self-checking bench for weight_tile_loader. Streams are
//               built from tile/row/byte arithmetic and the resulting pushes,
//               done timing and status flags are compared against them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_tile_loader;
    localparam int ROWS = 3;
    localparam int BPR  = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    weight_tile_loader_if bus ();

    weight_tile_loader #(
        .ROWS_PER_TILE (ROWS),
        .BYTES_PER_ROW (BPR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ldr (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [63:0] got_rows[$];
    int          push_cyc[$];
    int          done_cyc[$];
    int          ready_seen = 0;

    logic [7:0]  stream_q[$];
    logic [63:0] exp_rows[$];
    logic        exp_chk;

    // cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // observe pushes, done pulses and ready cycles mid-cycle
    always @(negedge clk) begin
        if (bus.wt_fifo_wr === 1'b1) begin
            got_rows.push_back(bus.wt_fifo_data);
            push_cyc.push_back(cyc);
        end
        if (bus.done === 1'b1) done_cyc.push_back(cyc);
        if (bus.in_ready === 1'b1) ready_seen <= ready_seen + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_in_ready"},   64'(bus.in_ready),   64'd0);
        chk({pfx, "_wr"},         64'(bus.wt_fifo_wr), 64'd0);
        chk({pfx, "_busy"},       64'(bus.busy),       64'd0);
        chk({pfx, "_done"},       64'(bus.done),       64'd0);
        chk({pfx, "_chk_err"},    64'(bus.chk_err),    64'd0);
        chk({pfx, "_data"},       bus.wt_fifo_data,    64'd0);
        chk({pfx, "_tile_count"}, 64'(bus.tile_count), 64'd0);
    endtask

    // Reference stream: pattern 0 gives bytes 1..ROWS*BPR per tile, else random.
    // With the checksum feature, each tile is followed by its XOR, corrupted where bad_mask is set.
    task automatic build(input int n, input int pattern, input logic [31:0] bad_mask);
        logic [7:0]  v;
        logic [7:0]  x;
        logic [63:0] row;
        stream_q.delete();
        exp_rows.delete();
        exp_chk = 1'b0;
        for (int t = 0; t < n; t++) begin
            x = 8'd0;
            for (int r = 0; r < ROWS; r++) begin
                row = 64'd0;
                for (int b = 0; b < BPR; b++) begin
                    v = (pattern == 0) ? 8'(r * BPR + b + 1) : 8'($urandom);
                    row = row + (64'(v) << (8 * b));
                    x = x ^ v;
                    stream_q.push_back(v);
                end
                exp_rows.push_back(row);
            end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            if (bad_mask[t]) begin
                stream_q.push_back(x ^ 8'h01);
                exp_chk = 1'b1;
            end else begin
                stream_q.push_back(x);
            end
`else
            if (bad_mask[t]) exp_chk = 1'b0;
`endif
        end
    endtask

    task automatic run_cmd(input int n, input int pct, input bit mid_start);
        int base;
        int dbase;
        int idx;
        int last_xfer;
        bit xfer;
        bit timed_out;
        base      = got_rows.size();
        dbase     = done_cyc.size();
        idx       = 0;
        last_xfer = 0;
        timed_out = 1'b1;
        bus.start     = 1'b1;
        bus.num_tiles = 8'(n);
        tick();
        bus.start = 1'b0;
        chk("busy_after_start",   64'(bus.busy),    64'd1);
        chk("chk_err_after_start", 64'(bus.chk_err), 64'd0);
        for (int k = 0; k < 4000; k++) begin
            if (done_cyc.size() > dbase) begin
                timed_out = 1'b0;
                break;
            end
            if (idx < stream_q.size() && $urandom_range(99) < pct) begin
                bus.in_valid = 1'b1;
                bus.in_data  = stream_q[idx];
            end else begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
            end
            if (mid_start && k == 5) begin
                bus.start     = 1'b1;
                bus.num_tiles = 8'(n + 2);
            end else begin
                bus.start = 1'b0;
            end
            xfer = bus.in_valid && bus.in_ready;
            if (xfer) last_xfer = cyc;
            tick();
            if (xfer) idx++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        chk("timeout",         64'(timed_out),                   64'd0);
        chk("push_count",      64'(got_rows.size() - base),      64'(exp_rows.size()));
        for (int i = 0; i < exp_rows.size(); i++) begin
            if (base + i < got_rows.size()) chk($sformatf("row%0d", i), got_rows[base + i], exp_rows[i]);
        end
        chk("bytes_used",      64'(idx),            64'(stream_q.size()));
        chk("tile_count",      64'(bus.tile_count), 64'(n));
        chk("busy_after_done", 64'(bus.busy),       64'd0);
        chk("chk_err",         64'(bus.chk_err),    64'(exp_chk));
        if (!timed_out && push_cyc.size() > 0) begin
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            chk("done_latency", 64'(done_cyc[dbase]), 64'(last_xfer + 1));
`else
            chk("done_latency", 64'(done_cyc[dbase]), 64'(push_cyc[push_cyc.size() - 1] + 1));
`endif
        end
        repeat (3) tick();
        chk("single_done",     64'(done_cyc.size() - dbase), 64'd1);
        chk("chk_err_hold",    64'(bus.chk_err),             64'(exp_chk));
    endtask

    initial begin
        int base;
        int dbase;
        int rbase;
        int s;
        int cnt;
        bit x;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.num_tiles = 8'd0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'd0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // one tile, bytes 1..9 back to back
        build(1, 0, 32'd0);
        run_cmd(1, 100, 1'b0);

        // zero tiles: done two cycles after start, nothing streamed
        base  = got_rows.size();
        dbase = done_cyc.size();
        rbase = ready_seen;
        bus.start     = 1'b1;
        bus.num_tiles = 8'd0;
        s = cyc;
        tick();
        bus.start = 1'b0;
        chk("z_busy_s1", 64'(bus.busy), 64'd1);
        chk("z_done_s1", 64'(bus.done), 64'd0);
        tick();
        chk("z_done_s2", 64'(bus.done), 64'd1);
        chk("z_busy_s2", 64'(bus.busy), 64'd1);
        tick();
        chk("z_busy_s3", 64'(bus.busy), 64'd0);
        chk("z_done_s3", 64'(bus.done), 64'd0);
        repeat (3) tick();
        chk("z_no_push",   64'(got_rows.size() - base),  64'd0);
        chk("z_no_ready",  64'(ready_seen - rbase),      64'd0);
        chk("z_one_done",  64'(done_cyc.size() - dbase), 64'd1);
        if (done_cyc.size() > dbase) chk("z_done_cycle", 64'(done_cyc[dbase]), 64'(s + 2));

        // two tiles, random bytes, 50% valid, a stray start mid-command
        build(2, 1, 32'd0);
        run_cmd(2, 50, 1'b1);

        // reset after 4 bytes of a tile
        build(1, 1, 32'd0);
        base = got_rows.size();
        bus.start     = 1'b1;
        bus.num_tiles = 8'd1;
        tick();
        bus.start = 1'b0;
        cnt = 0;
        for (int k = 0; k < 50 && cnt < 4; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = stream_q[cnt];
            x = bus.in_ready;
            tick();
            if (x) cnt++;
        end
        bus.in_valid = 1'b0;
        chk("rst_bytes_fed", 64'(cnt), 64'd4);
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        repeat (4) tick();
        chk("rst_pushes", 64'(got_rows.size() - base), 64'd1);
        if (got_rows.size() > base) chk("rst_row0", got_rows[base], exp_rows[0]);
        build(1, 1, 32'd0);
        run_cmd(1, 80, 1'b0);

        // two tiles of 1..9; second trailer wrong when checksums are enabled
        build(2, 0, 32'd2);
        run_cmd(2, 100, 1'b0);

        // a few randomized commands
        for (int it = 0; it < 3; it++) begin
            int n;
            n = int'($urandom_range(3, 1));
            build(n, 1, 32'($urandom));
            run_cmd(n, int'($urandom_range(100, 30)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
